// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control unit: default widths
// and the encoding of the EX operand-forwarding selects.
package pipe_ctrl_pkg;

  localparam int ADDR_LEN  = 5;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipe_ctrl_fwd_select.sv
// Forwarding select for one EX source operand; the younger M result wins
// over W, and x0 is never forwarded.
module fwd_select #(
  parameter int ADDR_LEN = pipe_ctrl_pkg::ADDR_LEN
) (
  input  logic [ADDR_LEN-1:0] rs,
  input  logic [ADDR_LEN-1:0] rd_m,
  input  logic [ADDR_LEN-1:0] rd_w,
  input  logic                v_m,
  input  logic                v_w,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  output logic [1:0]          sel
);
  import pipe_ctrl_pkg::*;

  always_comb begin
    sel = FWD_RF;
    if (rs != '0 && v_m && reg_write_m && rd_m == rs) begin
      sel = FWD_M;
    end else if (rs != '0 && v_w && reg_write_w && rd_w == rs) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: stage valids,
// EX forwarding selects, load-use stalls, branch flushes, multi-cycle EX.
module pipe_ctrl #(
  parameter int ADDR_LEN  = pipe_ctrl_pkg::ADDR_LEN,
  parameter int NUM_SRC   = 2,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic                        CLK,
  input  logic                        rst,
  input  logic                        fetch_valid,
  input  logic [NUM_SRC*ADDR_LEN-1:0] rs_d,
  input  logic [NUM_SRC*ADDR_LEN-1:0] rs_e,
  input  logic [ADDR_LEN-1:0]         rd_e,
  input  logic                        is_load_e,
  input  logic                        pc_src_e,
  input  logic                        ex_mc_start,
  input  logic [ADDR_LEN-1:0]         rd_m,
  input  logic [ADDR_LEN-1:0]         rd_w,
  input  logic                        reg_write_m,
  input  logic                        reg_write_w,
  output logic [NUM_SRC*2-1:0]        fwd_sel_e,
  output logic                        stall_f,
  output logic                        stall_d,
  output logic                        stall_e,
  output logic                        flush_d,
  output logic                        flush_e,
  output logic [CNT_W-1:0]            perf_stall_cnt,
  output logic [CNT_W-1:0]            perf_flush_cnt
);
  import pipe_ctrl_pkg::*;

  localparam int MC_W = $clog2(MC_CYCLES);
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_CYCLES - 1);
  localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);

  logic                 v_d, v_e, v_m, v_w;
  logic [MC_W-1:0]      mc_cnt;
  logic                 mc_start, mc_stall;
  logic                 lu, br;
  logic [NUM_SRC*2-1:0] fwd_raw;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(.ADDR_LEN(ADDR_LEN)) u_fwd (
      .rs          (rs_e[i*ADDR_LEN +: ADDR_LEN]),
      .rd_m        (rd_m),
      .rd_w        (rd_w),
      .v_m         (v_m),
      .v_w         (v_w),
      .reg_write_m (reg_write_m),
      .reg_write_w (reg_write_w),
      .sel         (fwd_raw[2*i +: 2])
    );
  end

  // A new multi-cycle request is only honoured while the counter is idle;
  // the final occupancy cycle (count of one) lets the op leave E.
  assign mc_start = (mc_cnt == '0) && ex_mc_start && v_e;
  assign mc_stall = (mc_cnt == '0) ? mc_start : (mc_cnt > MC_ONE);
  assign br       = v_e && pc_src_e && !mc_stall;

  always_comb begin
    lu = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v_e && is_load_e && rd_e != '0 && rd_e == rs_d[i*ADDR_LEN +: ADDR_LEN]) begin
        lu = 1'b1;
      end
    end
  end

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    fwd_sel_e = fwd_raw;
    if (rst) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      fwd_sel_e = '0;
    end else if (mc_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else if (br) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      v_d            <= 1'b0;
      v_e            <= 1'b0;
      v_m            <= 1'b0;
      v_w            <= 1'b0;
      mc_cnt         <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      v_d <= flush_d ? 1'b0 : (stall_d ? v_d : fetch_valid);
      v_e <= flush_e ? 1'b0 : (stall_e ? v_e : v_d);
      v_m <= stall_e ? 1'b0 : v_e;
      v_w <= v_m;
      if (mc_start) begin
        mc_cnt <= MC_LOAD;
      end else if (mc_cnt != '0) begin
        mc_cnt <= mc_cnt - MC_ONE;
      end
      // Counters stick at all-ones rather than wrapping.
      if (stall_f && perf_stall_cnt != '1) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if (br && perf_flush_cnt != '1) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int AL   = 5;
  localparam int NS   = 2;
  localparam int MC   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic             CLK = 1'b0;
  logic             rst, fetch_valid, is_load_e, pc_src_e, ex_mc_start;
  logic [NS*AL-1:0] rs_d, rs_e;
  logic [AL-1:0]    rd_e, rd_m, rd_w;
  logic             reg_write_m, reg_write_w;
  logic [NS*2-1:0]  fwd_sel_e;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e;
  logic [CW-1:0]    perf_stall_cnt, perf_flush_cnt;

  pipe_ctrl #(.ADDR_LEN(AL), .NUM_SRC(NS), .MC_CYCLES(MC), .CNT_W(CW)) dut (
    .CLK(CLK), .rst(rst), .fetch_valid(fetch_valid), .rs_d(rs_d), .rs_e(rs_e),
    .rd_e(rd_e), .is_load_e(is_load_e), .pc_src_e(pc_src_e), .ex_mc_start(ex_mc_start),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .fwd_sel_e(fwd_sel_e), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model state: stage valids, age of the multi-cycle op in E (-1 = none), counters.
  bit md, me, mm, mw;
  int age, sc, fc;

  logic [NS*2-1:0] last_fwd;
  logic            last_stall_f, last_stall_e, last_flush_d, last_flush_e;
  logic [CW-1:0]   last_pstall, last_pflush;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit fv, input logic [NS*AL-1:0] rsd,
                               input logic [NS*AL-1:0] rse, input logic [AL-1:0] rde,
                               input bit ld, input bit pc, input bit mci,
                               input logic [AL-1:0] rdm, input logic [AL-1:0] rdw,
                               input bit wm, input bit ww);
    bit mcs, lu, br, e_sf, e_sd, e_se, e_fd, e_fe, nd, ne, nm;
    logic [NS*2-1:0] e_fwd;
    logic [AL-1:0] s;
    rst = r; fetch_valid = fv; rs_d = rsd; rs_e = rse; rd_e = rde;
    is_load_e = ld; pc_src_e = pc; ex_mc_start = mci;
    rd_m = rdm; rd_w = rdw; reg_write_m = wm; reg_write_w = ww;
    #1;
    mcs = 0; lu = 0; br = 0;
    e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fwd = '0;
    if (r) begin
      e_fd = 1; e_fe = 1;
    end else begin
      mcs = (age < 0) ? (mci && me) : (age < MC - 1);
      for (int i = 0; i < NS; i++)
        if (me && ld && rde != 0 && rde == rsd[i*AL +: AL]) lu = 1;
      br = me && pc && !mcs;
      if (mcs) begin
        e_sf = 1; e_sd = 1; e_se = 1;
      end else if (br) begin
        e_fd = 1; e_fe = 1;
      end else if (lu) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
      for (int i = 0; i < NS; i++) begin
        s = rse[i*AL +: AL];
        if (s != 0 && mm && wm && rdm == s) e_fwd[2*i +: 2] = 2'b10;
        else if (s != 0 && mw && ww && rdw == s) e_fwd[2*i +: 2] = 2'b01;
      end
    end
    checkOutput("fwd_sel_e", fwd_sel_e, e_fwd);
    checkOutput("stall_f", stall_f, e_sf);
    checkOutput("stall_d", stall_d, e_sd);
    checkOutput("stall_e", stall_e, e_se);
    checkOutput("flush_d", flush_d, e_fd);
    checkOutput("flush_e", flush_e, e_fe);
    checkOutput("perf_stall_cnt", perf_stall_cnt, sc);
    checkOutput("perf_flush_cnt", perf_flush_cnt, fc);
    last_fwd = fwd_sel_e; last_stall_f = stall_f; last_stall_e = stall_e;
    last_flush_d = flush_d; last_flush_e = flush_e;
    last_pstall = perf_stall_cnt; last_pflush = perf_flush_cnt;
    if (r) begin
      md = 0; me = 0; mm = 0; mw = 0; age = -1; sc = 0; fc = 0;
    end else begin
      nd = e_fd ? 0 : (e_sd ? md : fv);
      ne = e_fe ? 0 : (e_se ? me : md);
      nm = e_se ? 0 : me;
      mw = mm; mm = nm; me = ne; md = nd;
      if (age < 0) age = mcs ? 1 : -1;
      else if (age < MC - 1) age++;
      else age = -1;
      if (e_sf && sc < CMAX) sc++;
      if (br && fc < CMAX) fc++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input bit fv);
    applyStimulus(0, fv, '0, '0, '0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic resetAndFill();
    applyStimulus(1, 0, '0, '0, '0, 0, 0, 0, '0, '0, 0, 0);
    repeat (4) idle(1);
  endtask

  initial begin
    logic [NS*AL-1:0] rsd, rse;
    rst = 1; fetch_valid = 0; rs_d = '0; rs_e = '0; rd_e = '0; is_load_e = 0;
    pc_src_e = 0; ex_mc_start = 0; rd_m = '0; rd_w = '0; reg_write_m = 0; reg_write_w = 0;
    md = 0; me = 0; mm = 0; mw = 0; age = -1; sc = 0; fc = 0;
    @(posedge CLK);
    #1;

    // Forwarding: M result, then W result, M priority, x0 never forwarded.
    resetAndFill();
    applyStimulus(0, 1, '0, {5'd3, 5'd5}, '0, 0, 0, 0, 5'd5, 5'd0, 1, 0);
    checkOutput("tp_fwd_m", last_fwd[1:0], 2'b10);
    applyStimulus(0, 1, '0, {5'd3, 5'd5}, '0, 0, 0, 0, 5'd0, 5'd5, 0, 1);
    checkOutput("tp_fwd_w", last_fwd[1:0], 2'b01);
    applyStimulus(0, 1, '0, {5'd0, 5'd7}, '0, 0, 0, 0, 5'd7, 5'd7, 1, 1);
    checkOutput("tp_fwd_prio", last_fwd, 4'b0010);
    applyStimulus(0, 1, '0, '0, '0, 0, 0, 0, 5'd0, 5'd0, 1, 1);
    checkOutput("tp_fwd_x0", last_fwd, 4'b0000);

    // Load-use stall for one cycle.
    resetAndFill();
    applyStimulus(0, 1, {5'd9, 5'd4}, '0, 5'd4, 1, 0, 0, '0, '0, 0, 0);
    checkOutput("tp_lu_stall_f", last_stall_f, 1'b1);
    checkOutput("tp_lu_flush_e", last_flush_e, 1'b1);
    idle(1);
    checkOutput("tp_lu_released", last_stall_f, 1'b0);
    checkOutput("tp_lu_perf", last_pstall, 4'd1);

    // Branch overrides a coincident load-use.
    resetAndFill();
    applyStimulus(0, 1, {5'd9, 5'd4}, '0, 5'd4, 1, 1, 0, '0, '0, 0, 0);
    checkOutput("tp_br_flush_d", last_flush_d, 1'b1);
    checkOutput("tp_br_stall_f", last_stall_f, 1'b0);
    idle(0);
    checkOutput("tp_br_perf_flush", last_pflush, 4'd1);
    checkOutput("tp_br_perf_stall", last_pstall, 4'd0);

    // Multi-cycle op: three stall cycles, branch pulse ignored meanwhile.
    resetAndFill();
    applyStimulus(0, 1, '0, '0, '0, 0, 0, 1, '0, '0, 0, 0);
    checkOutput("tp_mc_stall1", last_stall_e, 1'b1);
    applyStimulus(0, 1, '0, '0, '0, 0, 1, 0, '0, '0, 0, 0);
    checkOutput("tp_mc_stall2", last_stall_e, 1'b1);
    checkOutput("tp_mc_br_ignored", last_flush_d, 1'b0);
    idle(1);
    checkOutput("tp_mc_stall3", last_stall_e, 1'b1);
    idle(1);
    checkOutput("tp_mc_done", last_stall_e, 1'b0);

    // Reset in the second stall cycle, then a fresh full-length op.
    resetAndFill();
    applyStimulus(0, 1, '0, '0, '0, 0, 0, 1, '0, '0, 0, 0);
    applyStimulus(1, 1, '0, '0, '0, 0, 0, 0, '0, '0, 0, 0);
    checkOutput("tp_rst_flush", last_flush_e, 1'b1);
    idle(1);
    checkOutput("tp_rst_nostall", last_stall_e, 1'b0);
    checkOutput("tp_rst_perf", last_pstall, 4'd0);
    repeat (3) idle(1);
    for (int k = 0; k < MC; k++) begin
      applyStimulus(0, 1, '0, '0, '0, 0, 0, (k == 0), '0, '0, 0, 0);
      checkOutput("tp_mc_restart", last_stall_e, (k < MC - 1));
    end

    // Random traffic with small register indices so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        rsd[i*AL +: AL] = AL'($urandom_range(0, 7));
        rse[i*AL +: AL] = AL'($urandom_range(0, 7));
      end
      applyStimulus(($urandom_range(0, 59) == 0), $urandom_range(0, 1), rsd, rse,
                    AL'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    AL'($urandom_range(0, 7)), AL'($urandom_range(0, 7)),
                    $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
